clrx_axis_packer: RTL and testbench
===================================

# clrx_axis_packer

Downstream stage of the Camera Link receiver on the X channel: it takes the deserialized base-configuration port bytes and LVAL/FVAL/DVAL, qualifies pixels, frames them into an AXI4-Stream video stream (tuser = start of frame, tlast = end of line), and buffers them in a small FIFO against consumer backpressure. It also measures line length and frame height and flags overflow for the AXI-Lite status path.

## Interface
Parameters:
- FIFO_DEPTH, 16: output FIFO entries; power of two, 4..64.
- CNT_W, 16: width of the pixel/line measurement counters.

Ports:
- px_clk_x  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Ax, Bx, Cx  in  8 each  port bytes; pixel = {Cx,Bx,Ax}.
- LFDSx  in  4  bit0 LVAL, bit1 FVAL, bit2 DVAL, bit3 spare (ignored).
- strb_ABC_val_x  in  1  receiver word strobe; bytes valid this cycle.
- status_clr  in  1  single-cycle pulse; clears the overflow flag and frame_cnt.
- m_axis_tdata  out  24  pixel {Cx,Bx,Ax}.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  consumer ready.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- line_len  out  CNT_W  pixels in the last completed line.
- frame_lines  out  CNT_W  lines in the last completed frame.
- frame_cnt  out  CNT_W  completed frames since reset or clear.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.

## Operation
- Qualified pixel (q): strb_ABC_val_x & LVAL & FVAL, gated with DVAL per Configuration.
- Stage 1 registers the bytes, LFDSx and strb every cycle.
- FSM:
  - SYNC (reset state): discard everything; go to IDLE on the first registered FVAL=0. Frames already in progress at reset are dropped whole.
  - IDLE: go to FRAME on an FVAL 0→1 edge; set the sof_pending flag.
  - FRAME: process pixels; return to IDLE on FVAL 1→0.
- Hold register: each q pixel in FRAME goes to the hold register. The previous held pixel is pushed to the FIFO with tlast=0.
- On an LVAL 1→0 edge, or an FVAL 1→0 edge with a pixel held, the held pixel is pushed with tlast=1.
- The first push after sof_pending is set carries tuser=1, then sof_pending clears.
- Pixel counter: counts q pixels in a line. On LVAL fall, copy it to line_len and reset it to 0.
- Line counter: increments on each LVAL fall with ≥1 pixel. On FVAL fall, copy it to frame_lines, reset it to 0, and increment frame_cnt.
- Counters saturate at all-ones; no wrap.
- FIFO push when full with no pop this cycle: drop the word and set overflow. If the dropped word carried tuser or tlast, the marker moves to the next pushed word.
- A push and a pop in the same cycle with the FIFO full are allowed and lose nothing.
- FIFO is first-word-fall-through; AXI rules apply: tdata, tuser and tlast stay stable while tvalid=1 and tready=0, and tvalid never drops without a handshake.
- status_clr clears overflow and frame_cnt the next cycle. If a new overflow occurs in the same cycle, set wins.

## Timing
- Reset values: all outputs 0, FIFO empty, FSM in SYNC, hold register empty.
- Latency: a q pixel at the inputs in cycle t is on m_axis in cycle t+3 (FIFO empty, tready=1), provided cycle t+1 carries another q pixel or LVAL=0. Otherwise it waits in hold.
- line_len updates at t+2 after the LVAL-low input cycle. frame_lines and frame_cnt update at t+2 after the FVAL-low input cycle.
- Throughput: one pixel per clock sustained with tready=1.
- Reset mid-line: FIFO and hold are flushed; a partial line is never emitted.

## Configuration
- CLRX_PACK_DVAL_EN defined: q additionally requires DVAL=1.
- CLRX_PACK_DVAL_EN undefined: DVAL is ignored (cameras that tie DVAL low still stream).

## Test plan
- Frame of 3 lines × 8 pixels, data = incrementing from 0x000001, tready=1 → 24 beats in order; tuser only on 0x000001; tlast on beats 8, 16, 24; line_len=8, frame_lines=3, frame_cnt=1.
- Reset released with FVAL=1 mid-frame → no output until the next full frame; that frame is emitted complete with tuser on its first pixel.
- tready=0 for 40 cycles during a 32-pixel line, FIFO_DEPTH=16 → overflow=1. The beats after the first 17 buffered pixels are dropped; tlast still appears on the final emitted beat; status_clr clears overflow.
- tready toggled 1/0 every cycle on a 2×16 frame → all 32 beats delivered; tdata, tuser and tlast stable while stalled; no duplicates.
- DVAL=0 throughout a 1×4 frame → with CLRX_PACK_DVAL_EN: zero beats and line_len unchanged; without it: 4 beats, the last with tlast.
- strb_ABC_val_x low every other cycle within LVAL, 6 pixels → 6 contiguous beats with tlast on the 6th; line_len=6.

Source files
------------

// File: rtl/clrx_axis_packer.sv
// Camera Link X-channel packer: qualifies pixels, frames them as AXI4-Stream video (tuser=SOF, tlast=EOL)
// through a first-word-fall-through FIFO and measures line/frame geometry. Option: CLRX_PACK_DVAL_EN.
module clrx_axis_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             px_clk_x,
  input  logic             rst,
  input  logic [7:0]       Ax,
  input  logic [7:0]       Bx,
  input  logic [7:0]       Cx,
  input  logic [3:0]       LFDSx,
  input  logic             strb_ABC_val_x,
  input  logic             status_clr,
  output logic [23:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  logic [23:0] pix_s1_q;
  logic [2:0]  lfds_s1_q;
  logic        strb_s1_q, s1_vld_q, lval_p_q, fval_p_q;

  always_ff @(posedge px_clk_x or posedge rst) begin
    if (rst) begin
      pix_s1_q  <= '0;
      lfds_s1_q <= '0;
      strb_s1_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      lval_p_q  <= 1'b0;
      fval_p_q  <= 1'b0;
    end else begin
      pix_s1_q  <= {Cx, Bx, Ax};
      lfds_s1_q <= LFDSx[2:0];
      strb_s1_q <= strb_ABC_val_x;
      s1_vld_q  <= 1'b1;
      lval_p_q  <= lfds_s1_q[0];
      fval_p_q  <= lfds_s1_q[1];
    end
  end

  logic lval, fval, lval_fall, fval_fall, fval_rise, q;
  logic unused_spare;
  assign lval      = lfds_s1_q[0];
  assign fval      = lfds_s1_q[1];
  assign lval_fall = lval_p_q & ~lval;
  assign fval_fall = fval_p_q & ~fval;
  assign fval_rise = fval & ~fval_p_q;
`ifdef CLRX_PACK_DVAL_EN
  assign q            = strb_s1_q & lval & fval & lfds_s1_q[2];
  assign unused_spare = LFDSx[3];
`else
  assign q            = strb_s1_q & lval & fval;
  assign unused_spare = ^{LFDSx[3], lfds_s1_q[2]};
`endif

  logic [1:0]       state_q, state_d;
  logic [23:0]      hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d, sof_pend_q, sof_pend_d, last_pend_q, last_pend_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, line_len_q, line_len_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d, frame_cnt_q, frame_cnt_d;
  logic             ovf_q, ovf_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [25:0]      mem_q [FIFO_DEPTH];
  logic [25:0]      wr_word, rd_word;
  logic             active, push, push_last, wr_en, pop, fifo_empty, fifo_full;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & m_axis_tready;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    sof_pend_d    = sof_pend_q;
    last_pend_d   = last_pend_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_cnt_d   = status_clr ? '0 : frame_cnt_q;
    ovf_d         = status_clr ? 1'b0 : ovf_q;
    active        = 1'b0;
    push          = 1'b0;
    push_last     = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      ST_SYNC:  if (s1_vld_q && !fval) state_d = ST_IDLE;
      ST_IDLE:  if (fval_rise) begin
                  state_d    = ST_FRAME;
                  sof_pend_d = 1'b1;
                  active     = 1'b1;
                end
      ST_FRAME: begin
                  active = 1'b1;
                  if (fval_fall) state_d = ST_IDLE;
                end
      default:  state_d = ST_SYNC;
    endcase
    if (active) begin
      if (q) begin
        push       = hold_vld_q;
        hold_d     = pix_s1_q;
        hold_vld_d = 1'b1;
        pix_cnt_d  = sat_inc(pix_cnt_q);
      end else if ((lval_fall || fval_fall) && hold_vld_q) begin
        push       = 1'b1;
        push_last  = 1'b1;
        hold_vld_d = 1'b0;
      end
      // Empty lines neither update line_len nor count as a line.
      if (lval_fall) begin
        pix_cnt_d = '0;
        if (pix_cnt_q != '0) begin
          line_len_d = pix_cnt_q;
          line_cnt_d = sat_inc(line_cnt_q);
        end
      end
      if (fval_fall) begin
        frame_lines_d = line_cnt_d;
        line_cnt_d    = '0;
        pix_cnt_d     = '0;
        frame_cnt_d   = sat_inc(frame_cnt_d);
      end
    end
    wr_word = {sof_pend_q, push_last | last_pend_q, hold_q};
    if (push) begin
      // A dropped word leaves its markers pending for the next accepted word.
      if (fifo_full && !pop) begin
        ovf_d       = 1'b1;
        last_pend_d = wr_word[24];
      end else begin
        wr_en       = 1'b1;
        sof_pend_d  = 1'b0;
        last_pend_d = 1'b0;
      end
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge px_clk_x or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      sof_pend_q    <= 1'b0;
      last_pend_q   <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_cnt_q   <= '0;
      ovf_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      sof_pend_q    <= sof_pend_d;
      last_pend_q   <= last_pend_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      ovf_q         <= ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge px_clk_x) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  assign rd_word       = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : rd_word[23:0];
  assign m_axis_tuser  = ~fifo_empty & rd_word[25];
  assign m_axis_tlast  = ~fifo_empty & rd_word[24];
  assign line_len      = line_len_q;
  assign frame_lines   = frame_lines_q;
  assign frame_cnt     = frame_cnt_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_clrx_axis_packer.sv
// Scoreboard bench for clrx_axis_packer: stimulus queues expected beats and status values,
// an independent negedge monitor pops and compares them.
module tb_clrx_axis_packer;
  logic        px_clk_x = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  Ax = '0, Bx = '0, Cx = '0;
  logic [3:0]  LFDSx = '0;
  logic        strb_ABC_val_x = 1'b0, status_clr = 1'b0, m_axis_tready = 1'b1;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow;
  logic [15:0] line_len, frame_lines, frame_cnt;

  localparam int T_VALID = 0, T_DATA = 1, T_LLEN = 2, T_FLINES = 3, T_FCNT = 4, T_OVF = 5, T_DRAIN = 6;

  typedef struct { int tag; logic [31:0] exp; } st_t;
  st_t         st_q[$];
  logic [25:0] exp_q[$];
  int          checks = 0, errors = 0;
  logic        stall_chk = 1'b0;
  logic [25:0] stall_word = '0;
  logic        tog_en = 1'b0;
  logic [23:0] nxt_px = 24'h000001;

  always #5 px_clk_x = ~px_clk_x;

  clrx_axis_packer #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .px_clk_x(px_clk_x), .rst(rst), .Ax(Ax), .Bx(Bx), .Cx(Cx), .LFDSx(LFDSx),
    .strb_ABC_val_x(strb_ABC_val_x), .status_clr(status_clr),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .line_len(line_len),
    .frame_lines(frame_lines), .frame_cnt(frame_cnt), .overflow(overflow));

  always @(negedge px_clk_x) begin : monitor
    st_t         s;
    logic [31:0] act;
    logic [25:0] got, e;
    string       nm;
    while (st_q.size() != 0) begin
      s = st_q.pop_front();
      case (s.tag)
        T_VALID:  begin nm = "tvalid";      act = {31'b0, m_axis_tvalid}; end
        T_DATA:   begin nm = "tdata";       act = {8'b0, m_axis_tdata};   end
        T_LLEN:   begin nm = "line_len";    act = {16'b0, line_len};      end
        T_FLINES: begin nm = "frame_lines"; act = {16'b0, frame_lines};   end
        T_FCNT:   begin nm = "frame_cnt";   act = {16'b0, frame_cnt};     end
        T_OVF:    begin nm = "overflow";    act = {31'b0, overflow};      end
        default:  begin nm = "beats_left";  act = exp_q.size();           end
      endcase
      checks++;
      if (act !== s.exp) begin
        errors++;
        $display("FAIL %s got=%0h exp=%0h", nm, act, s.exp);
      end
    end
    got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (rst) stall_chk = 1'b0;
    else begin
      if (stall_chk) begin
        checks++;
        if (!m_axis_tvalid || got !== stall_word) begin
          errors++;
          $display("FAIL stall_hold got=%h/%b exp=%h/1", got, m_axis_tvalid, stall_word);
        end
      end
      stall_chk = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra got=%h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL beat got=%h exp=%h (user,last,data)", got, e);
          end
        end
      end else if (m_axis_tvalid) begin
        stall_chk  = 1'b1;
        stall_word = got;
      end
    end
  end

  task automatic chk(input int tag, input logic [31:0] e);
    st_q.push_back('{tag, e});
  endtask

  task automatic step(input int lv, input int fv, input int dv, input int st, input logic [23:0] px);
    LFDSx          = {1'b0, 1'(dv), 1'(fv), 1'(lv)};
    strb_ABC_val_x = 1'(st);
    {Cx, Bx, Ax}   = px;
    if (tog_en) m_axis_tready = ~m_axis_tready;
    @(posedge px_clk_x);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1, 0, 24'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      idle(1);
      n++;
    end
    idle(3);
    chk(T_DRAIN, 0);
  endtask

  task automatic frame(input int nl, input int ppl, input int sparse, input int dv, input int exp_en);
    step(0, 1, dv, 0, 24'h0);
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < ppl; p++) begin
        if (exp_en != 0) exp_q.push_back({(l == 0 && p == 0), (p == ppl - 1), nxt_px});
        step(1, 1, dv, 1, nxt_px);
        nxt_px = nxt_px + 24'd1;
        if (sparse != 0) step(1, 1, dv, 0, 24'h0);
      end
      repeat (10) step(0, 1, dv, 0, 24'h0);
    end
    repeat (3) step(0, 0, dv, 0, 24'h0);
  endtask

  initial begin
    repeat (3) @(posedge px_clk_x);
    #1;
    chk(T_VALID, 0); chk(T_DATA, 0); chk(T_LLEN, 0); chk(T_FLINES, 0); chk(T_FCNT, 0); chk(T_OVF, 0);
    rst = 1'b0;
    idle(4);

    // 3 x 8 frame, pixels 0x000001..0x000018
    frame(3, 8, 0, 1, 1);
    drain();
    chk(T_LLEN, 8); chk(T_FLINES, 3); chk(T_FCNT, 1);

    // reset with pixels stuck in FIFO/hold, released mid-frame: nothing of that frame may appear
    m_axis_tready = 1'b0;
    step(0, 1, 1, 0, 24'h0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 24'hA00000 + 24'(i));
    rst = 1'b1;
    step(1, 1, 1, 1, 24'hA00010);
    step(1, 1, 1, 1, 24'hA00011);
    chk(T_VALID, 0); chk(T_FCNT, 0);
    m_axis_tready = 1'b1;
    step(1, 1, 1, 1, 24'hA00012);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 24'hA00020 + 24'(i));
    repeat (2) step(0, 1, 1, 0, 24'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 24'hA00030 + 24'(i));
    repeat (2) step(0, 1, 1, 0, 24'h0);
    repeat (3) step(0, 0, 1, 0, 24'h0);
    chk(T_VALID, 0); chk(T_LLEN, 0); chk(T_FCNT, 0);
    frame(1, 5, 0, 1, 1);
    drain();
    chk(T_LLEN, 5); chk(T_FLINES, 1); chk(T_FCNT, 1);

    // 32 sparse pixels, tready low for the first 40 steps: FIFO fills with p1..p16,
    // pushes of p17..p19 hit a full FIFO, p20 onward fit once draining starts
    step(0, 1, 1, 0, 24'h0);
    for (int s = 0; s < 64; s++) begin
      m_axis_tready = (s >= 40);
      if (s % 2 == 0) begin
        if (s / 2 < 16 || s / 2 >= 19)
          exp_q.push_back({(s == 0), (s == 62), nxt_px});
        step(1, 1, 1, 1, nxt_px);
        nxt_px = nxt_px + 24'd1;
      end else step(1, 1, 1, 0, 24'h0);
    end
    repeat (2) step(0, 1, 1, 0, 24'h0);
    repeat (3) step(0, 0, 1, 0, 24'h0);
    drain();
    chk(T_OVF, 1); chk(T_LLEN, 32); chk(T_FLINES, 1); chk(T_FCNT, 2);
    status_clr = 1'b1;
    idle(1);
    status_clr = 1'b0;
    chk(T_OVF, 0); chk(T_FCNT, 0);

    // tready toggling every cycle on a 2 x 16 frame
    tog_en = 1'b1;
    frame(2, 16, 0, 1, 1);
    drain();
    tog_en        = 1'b0;
    m_axis_tready = 1'b1;
    chk(T_LLEN, 16); chk(T_FLINES, 2); chk(T_FCNT, 1); chk(T_OVF, 0);

    // DVAL held low on a 1 x 4 frame
`ifdef CLRX_PACK_DVAL_EN
    frame(1, 4, 0, 0, 0);
    drain();
    chk(T_LLEN, 16); chk(T_FLINES, 0);
`else
    frame(1, 4, 0, 0, 1);
    drain();
    chk(T_LLEN, 4); chk(T_FLINES, 1);
`endif
    chk(T_FCNT, 2);

    // strobe low every other cycle within LVAL, 6 pixels
    frame(1, 6, 1, 1, 1);
    drain();
    chk(T_LLEN, 6); chk(T_FLINES, 1); chk(T_FCNT, 3);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end
endmodule
